avalon_st_packet_arbiter: RTL and testbench

//  Shares one Avalon-ST sink among NUM_SRC already-enforced Avalon-ST sources, with packet-level round-robin arbitration.
//  A grant is locked from SOP to EOP, so packets are never interleaved on the output.

---
 rtl/avalon_st_packet_arbiter.sv | 118 +++++++++++
 tb/tb_avalon_st_packet_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_packet_arbiter.sv
// Packet-level round-robin arbiter that merges NUM_SRC Avalon-ST sources onto one sink.
// A grant is taken at SOP and held until the EOP beat transfers, so packets never interleave.
module avalon_st_packet_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned EMPTY_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           in_valid,
  input  logic [NUM_SRC-1:0]           in_sop,
  input  logic [NUM_SRC-1:0]           in_eop,
  input  logic [NUM_SRC*DATA_W-1:0]    in_data,
  input  logic [NUM_SRC*EMPTY_W-1:0]   in_empty,
  output logic [NUM_SRC-1:0]           in_rdy,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [DATA_W-1:0]            out_data,
  output logic [EMPTY_W-1:0]           out_empty,
  input  logic                         out_rdy,
  output logic [$clog2(NUM_SRC)-1:0]   grant_idx,
  output logic                         busy,
  output logic                         stray_beat
);

  localparam int unsigned GW = $clog2(NUM_SRC);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      grant_idx_q, grant_idx_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      winner;
  logic [GW-1:0]      cand;
  logic [NUM_SRC-1:0] request;
  logic [NUM_SRC-1:0] stray_mask;

  assign request    = in_valid & in_sop;
  assign grant_idx  = grant_idx_q;
  assign busy       = (state_q == LOCKED);
  assign stray_beat = |stray_mask;

  // Round-robin pick: scan from the far end down so the nearest requester after last_grant wins.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int unsigned off = NUM_SRC; off > 0; off--) begin
      cand = GW'((32'(last_grant_q) + off) % NUM_SRC);
      if (request[cand]) begin
        winner = cand;
      end
    end
  end

  // Zero-latency pass-through of the locked source; everything else is held off and zeroed.
  always_comb begin
    in_rdy     = '0;
    out_valid  = 1'b0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    out_data   = '0;
    out_empty  = '0;
    stray_mask = in_valid & ~in_sop;
    if (state_q == LOCKED) begin
      out_valid               = in_valid[grant_idx_q];
      in_rdy[grant_idx_q]     = out_rdy;
      stray_mask[grant_idx_q] = 1'b0;
      if (out_valid) begin
        out_sop  = in_sop[grant_idx_q];
        out_eop  = in_eop[grant_idx_q];
        out_data = in_data[32'(grant_idx_q)*DATA_W +: DATA_W];
        if (out_eop) begin
          out_empty = in_empty[32'(grant_idx_q)*EMPTY_W +: EMPTY_W];
        end
      end
    end
  end

  // Next-state: lock on any SOP request, release when the EOP beat transfers.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (|request) begin
          state_d     = LOCKED;
          grant_idx_d = winner;
        end
      end
      LOCKED: begin
        if (out_valid && out_rdy && in_eop[grant_idx_q]) begin
          state_d      = IDLE;
          last_grant_d = grant_idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= GW'(NUM_SRC - 1);
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_avalon_st_packet_arbiter.sv
// Scoreboard bench for avalon_st_packet_arbiter: per-source beat queues drive the inputs,
// expected output beats are queued in grant order and a monitor pops them on every transfer.
module tb_avalon_st_packet_arbiter;

  localparam int unsigned NSRC = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned EW   = 2;
  localparam int unsigned GW   = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NSRC-1:0]      in_valid = '0;
  logic [NSRC-1:0]      in_sop   = '0;
  logic [NSRC-1:0]      in_eop   = '0;
  logic [NSRC*DW-1:0]   in_data  = '0;
  logic [NSRC*EW-1:0]   in_empty = '0;
  logic [NSRC-1:0]      in_rdy;
  logic                 out_valid, out_sop, out_eop;
  logic [DW-1:0]        out_data;
  logic [EW-1:0]        out_empty;
  logic                 out_rdy = 1'b1;
  logic [GW-1:0]        grant_idx;
  logic                 busy, stray_beat;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
  } beat_t;

  typedef struct packed {
    logic [GW-1:0] g;
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
  } exp_t;

  beat_t           sq [NSRC][$];
  exp_t            exp_q [$];
  int              checks = 0;
  int              passes = 0;
  int              cyc = 0;
  logic [NSRC-1:0] fire = '0;
  logic            chk_gap = 1'b0;
  logic            eop_seen = 1'b0;
  int              last_eop_cyc = 0;

  avalon_st_packet_arbiter #(
    .NUM_SRC (NSRC),
    .DATA_W  (DW),
    .EMPTY_W (EW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_data    (in_data),
    .in_empty   (in_empty),
    .in_rdy     (in_rdy),
    .out_valid  (out_valid),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_data   (out_data),
    .out_empty  (out_empty),
    .out_rdy    (out_rdy),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .stray_beat (stray_beat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Source models: present the head beat, pop it after a handshake.
  always @(negedge clk) fire = in_valid & in_rdy;

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NSRC; i++) begin
      if (fire[i] && sq[i].size() > 0) void'(sq[i].pop_front());
      if (sq[i].size() > 0) begin
        in_valid[i]           = 1'b1;
        in_sop[i]             = sq[i][0].sop;
        in_eop[i]             = sq[i][0].eop;
        in_data[i*DW +: DW]   = sq[i][0].data;
        in_empty[i*EW +: EW]  = sq[i][0].empty;
      end else begin
        in_valid[i]           = 1'b0;
        in_sop[i]             = 1'b0;
        in_eop[i]             = 1'b0;
        in_data[i*DW +: DW]   = '0;
        in_empty[i*EW +: EW]  = '0;
      end
    end
  end

  // Monitor: every transferring output beat must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) eop_seen = 1'b0;
    if (out_valid && out_rdy) begin
      chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", 64'({grant_idx, out_sop, out_eop, out_data, out_empty}), 64'(e));
        if (chk_gap && out_sop && eop_seen) chk("bubble", 64'(cyc - last_eop_cyc), 64'd2);
        if (out_eop) begin
          eop_seen     = 1'b1;
          last_eop_cyc = cyc;
        end
      end
    end
  end

  // Queue an n-beat packet on source s; the first npush beats are expected on the output.
  task automatic load(input int s, input int n, input logic [7:0] tag,
                      input logic [EW-1:0] last_empty, input int npush);
    for (int b = 0; b < n; b++) begin
      beat_t bt;
      bt.sop   = (b == 0);
      bt.eop   = (b == n - 1);
      bt.data  = {tag, 8'(s), 16'(b)};
      bt.empty = bt.eop ? last_empty : 2'd3;
      sq[s].push_back(bt);
      if (b < npush) exp_q.push_back({GW'(s), bt.sop, bt.eop, bt.data, bt.eop ? bt.empty : 2'd0});
    end
  endtask

  task automatic drain();
    int pend;
    int n;
    pend = 1;
    n = 0;
    while (pend != 0 && n < 200) begin
      @(negedge clk);
      n++;
      pend = exp_q.size();
      for (int i = 0; i < NSRC; i++) pend += sq[i].size();
    end
    chk("drain", 64'(pend), 64'd0);
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NSRC; i++) sq[i].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_idx), 64'd0);
    chk("rst_out", 64'({out_valid, out_sop, out_eop, out_data, out_empty}), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    @(posedge clk); #1 rst = 1'b1;

    // 1: three-beat packet on src1, one arbitration bubble
    @(posedge clk); #1;
    load(1, 3, 8'h10, 2'd1, 3);
    @(negedge clk);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_idle_rdy", 64'(in_rdy), 64'd0);
    @(negedge clk);
    chk("t1_lock_busy", 64'(busy), 64'd1);
    chk("t1_lock_grant", 64'(grant_idx), 64'd1);
    drain();

    // 2: all sources request, order 0,1,2,3,0 with one bubble between packets
    reset_dut();
    chk_gap = 1'b1;
    @(posedge clk); #1;
    load(0, 2, 8'h20, 2'd0, 2);
    load(1, 2, 8'h21, 2'd1, 2);
    load(2, 2, 8'h22, 2'd2, 2);
    load(3, 2, 8'h23, 2'd3, 2);
    load(0, 2, 8'h24, 2'd1, 2);
    drain();
    chk_gap = 1'b0;

    // 3: backpressure mid-packet on src2, src0 waits for the EOP
    @(posedge clk); #1;
    load(2, 4, 8'h30, 2'd2, 4);
    repeat (3) @(posedge clk);
    #1 out_rdy = 1'b0;
    load(0, 2, 8'h31, 2'd1, 2);
    repeat (5) begin
      @(negedge clk);
      chk("t3_stall_rdy", 64'(in_rdy), 64'd0);
      chk("t3_stall_data", 64'(out_data), 64'({8'h30, 8'd2, 16'd2}));
      chk("t3_stall_grant", 64'({busy, grant_idx}), 64'({1'b1, 2'd2}));
      chk("t3_stray", 64'(stray_beat), 64'd0);
    end
    @(posedge clk); #1 out_rdy = 1'b1;
    drain();

    // 4: single-beat packet on src3 with empty=2
    @(posedge clk); #1;
    load(3, 1, 8'h40, 2'd2, 1);
    drain();
    chk("t4_back_idle", 64'(busy), 64'd0);

    // 5: valid without sop on src1 while idle
    @(posedge clk); #1;
    sq[1].push_back('{sop: 1'b0, eop: 1'b0, data: 32'h5555_0001, empty: 2'd0});
    @(negedge clk);
    chk("t5_stray", 64'(stray_beat), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rdy", 64'(in_rdy), 64'd0);
    @(negedge clk);
    chk("t5_no_grant", 64'({busy, in_rdy[1]}), 64'd0);
    @(posedge clk); #1;
    sq[1].delete();
    @(negedge clk);
    chk("t5_stray_clear", 64'(stray_beat), 64'd0);

    // 6: reset mid-packet on src0 after src0 was the last grant
    @(posedge clk); #1;
    load(0, 1, 8'h50, 2'd0, 1);
    drain();
    @(posedge clk); #1;
    load(0, 4, 8'h60, 2'd1, 2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    sq[0].delete();
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rdy", 64'(in_rdy), 64'd0);
    chk("t6_grant", 64'(grant_idx), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    load(0, 1, 8'h70, 2'd0, 1);
    load(1, 1, 8'h71, 2'd1, 1);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
